// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART frame parser.
// The defaults here are also used by the integration top.
package uart_frame_pkg;

    localparam logic [7:0]  SofByte   = 8'hA5;
    localparam int unsigned DefMaxLen = 16;
    localparam int unsigned DefGapCyc = 104_170;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StChk,
        StSend
    } state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: Depth x 8 register array.
// Synchronous write port, asynchronous read port.
module uart_frame_buf #(
    parameter int unsigned Depth = 16,
    parameter int unsigned IdxW  = 5
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] waddr_i,
    input  logic [7:0]      wdata_i,
    input  logic [IdxW-1:0] raddr_i,
    output logic [7:0]      rdata_o
);

    logic [7:0] mem_q [Depth];

    // Decoded compare keeps the full index width meaningful for any Depth.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (we_i && (waddr_i == IdxW'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        for (int i = 0; i < Depth; i++) begin
            if (raddr_i == IdxW'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser for SOF/LEN/payload/CHK byte frames from the UART receiver.
// Buffers a frame, verifies its checksum, then streams the payload out.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN = DefMaxLen,
    parameter int unsigned GAP_CYC = DefGapCyc
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_gap,
    output logic       err_ovr
);

    localparam int unsigned IdxW    = $clog2(MAX_LEN + 1);
    localparam int unsigned GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(GAP_CYC - 1);
    localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
    localparam logic [IdxW-1:0] One = IdxW'(1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] len_q, len_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]      sum_q, sum_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            frame_ok_q, frame_ok_d;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            err_gap_q, err_gap_d;
    logic            err_ovr_q, err_ovr_d;
    logic            buf_we;
    logic [7:0]      buf_rdata;

    uart_frame_buf #(
        .Depth (MAX_LEN),
        .IdxW  (IdxW)
    ) u_buf (
        .clk_i   (sys_clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (rx_data),
        .raddr_i (rd_idx_d),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rd_idx_d    = rd_idx_q;
        sum_d       = sum_q;
        gap_d       = '0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        err_gap_d   = 1'b0;
        err_ovr_d   = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && (rx_data == SofByte)) begin
                    state_d = StLen;
                end
            end
            StLen, StPayload, StChk: begin
                if (rx_valid) begin
                    if (state_q == StLen) begin
                        if ((rx_data == 8'h00) || (rx_data > MaxLenB)) begin
                            err_len_d = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            len_d   = IdxW'(rx_data);
                            sum_d   = rx_data;
                            idx_d   = '0;
                            state_d = StPayload;
                        end
                    end else if (state_q == StPayload) begin
                        buf_we = 1'b1;
                        sum_d  = sum_q + rx_data;
                        idx_d  = idx_q + One;
                        if (idx_q == len_q - One) begin
                            state_d = StChk;
                        end
                    end else if (rx_data == sum_q) begin
                        frame_ok_d  = 1'b1;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (len_q == One);
                        state_d     = StSend;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (gap_q == GapMax) begin
                    err_gap_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StSend: begin
                err_ovr_d = rx_valid;
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        rd_idx_d   = rd_idx_q + One;
                        out_last_d = ((rd_idx_q + One) == (len_q - One));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Separate block so the buffer read path does not loop through the FSM block.
    always_comb begin
        out_data_d = out_data_q;
        if (state_d == StSend) begin
            out_data_d = buf_rdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            rd_idx_q    <= '0;
            sum_q       <= 8'h00;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_gap_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_idx_q    <= rd_idx_d;
            sum_q       <= sum_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            err_gap_q   <= err_gap_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign err_chk   = err_chk_q;
    assign err_len   = err_len_q;
    assign err_gap   = err_gap_q;
    assign err_ovr   = err_ovr_q;

endmodule
